sdram_pll_reset_sequencer: RTL and testbench

- Sequences power-up and recovery of the SDRAM/system PLL: drives the PLL reset, waits for and qualifies the PLL `locked` output, and releases a reset for the clocked-domain logic (SDRAM controller) only after lock is stable.
- Retries on lock timeout, reports hard fault after repeated failures, counts lock-loss events in operation.
- Runs on the 50 MHz reference clock that also feeds the PLL.

---
 rtl/sdram_pll_reset_sequencer.sv | 124 ++++++++++++
 tb/tb_sdram_pll_reset_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer on the 50 MHz reference clock.
// Holds the PLL in reset, waits for a stable lock, and only then releases the PLL-clocked domain.
module sdram_pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES    = 10,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3,
  parameter int TIMER_W            = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       domain_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]         RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         retry_n;
  logic [7:0]         loss_n;
  logic               locked_m, locked_s;

  assign state_dbg = state;

  // pll_locked is asynchronous to refclk; only locked_s may be used by the FSM.
  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
    end
  end

  // relock_req is a one-cycle strobe with no back-pressure; it is acted on only in RUN and FAULT.
  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    loss_n  = lock_loss_cnt;
    case (state)
      S_RESET_PLL: begin
        if (timer == HOLD_LAST) state_n = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_n = S_STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          retry_n = retry_cnt + 4'd1;
          state_n = (retry_n == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_n = S_WAIT_LOCK;
        end else if (timer == STABLE_LAST) begin
          state_n = S_RUN;
          retry_n = 4'd0;
        end
      end
      S_RUN: begin
        // A lock loss coinciding with relock_req is still counted exactly once.
        if (!locked_s) begin
          if (lock_loss_cnt != 8'hFF) loss_n = lock_loss_cnt + 8'd1;
          state_n = S_RESET_PLL;
        end else if (relock_req) begin
          state_n = S_RESET_PLL;
        end
      end
      S_FAULT: begin
        if (relock_req) begin
          retry_n = 4'd0;
          state_n = S_RESET_PLL;
        end
      end
      default: state_n = S_RESET_PLL;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= S_RESET_PLL;
      timer         <= '0;
      retry_cnt     <= 4'd0;
      lock_loss_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      domain_rst    <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      retry_cnt     <= retry_n;
      lock_loss_cnt <= loss_n;
      if (state_n != state)                      timer <= '0;
      else if (state == S_RUN || state == S_FAULT) timer <= timer;
      else                                       timer <= timer + TIMER_W'(1);
      pll_rst       <= (state_n == S_RESET_PLL);
      domain_rst    <= (state_n != S_RUN);
      ready         <= (state_n == S_RUN);
      fault         <= (state_n == S_FAULT);
    end
  end

endmodule

// File: tb/tb_sdram_pll_reset_sequencer.sv
// Bench for sdram_pll_reset_sequencer: directed stimulus pushes timed output events into a queue,
// an independent monitor pops one entry per observed output change and compares value and cycle.
module tb_sdram_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       domain_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_dbg;

  sdram_pll_reset_sequencer #(
    .RST_HOLD_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(2),
    .TIMER_W(17)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .domain_rst(domain_rst),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  int cyc = 0;
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // Entry: {cycle[31:0], pll_rst, domain_rst, ready, fault, retry_cnt[3:0], lock_loss_cnt[7:0]}
  logic [47:0] exp_q[$];
  logic [15:0] prev_out;
  logic        mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_loss;

  function automatic logic [15:0] pk(input logic [3:0] flags, input logic [3:0] rc,
                                     input logic [7:0] lc);
    return {flags, rc, lc};
  endfunction

  function automatic logic [15:0] cur_out();
    return {pll_rst, domain_rst, ready, fault, retry_cnt, lock_loss_cnt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic expect_at(input int dt, input logic [15:0] v);
    exp_q.push_back({32'(cyc + dt), v});
  endtask

  // Drop lock in RUN for 5 cycles and relock; returns to RUN 16 cycles after the drop.
  task automatic loss_cycle();
    if (exp_loss != 8'hFF) exp_loss = exp_loss + 8'd1;
    pll_locked = 1'b0;
    expect_at(3, pk(4'b1100, 4'd0, exp_loss));
    step(5);
    pll_locked = 1'b1;
    expect_at(2, pk(4'b0100, 4'd0, exp_loss));
    expect_at(11, pk(4'b0010, 4'd0, exp_loss));
    step(12);
  endtask

  // ---------------- monitor ----------------
  logic [47:0] head;
  logic [15:0] now_out;
  always @(negedge refclk) begin
    if (mon_en) begin
      now_out = cur_out();
      n_tests++;
      if (ready !== ~domain_rst || (domain_rst === 1'b0 && state_dbg !== 3'd3)) begin
        n_fail++;
        $display("FAIL rst_ready_pair cyc=%0d got domain_rst=%b ready=%b state=%0d required complementary, release only in RUN",
                 cyc, domain_rst, ready, state_dbg);
      end
      if (now_out !== prev_out) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got out=%h required out=%h (no change expected)",
                   cyc, now_out, prev_out);
        end else begin
          head = exp_q.pop_front();
          if (head[47:16] != 32'(cyc) || head[15:0] !== now_out) begin
            n_fail++;
            $display("FAIL output_event got out=%h at cyc %0d required out=%h at cyc %0d",
                     now_out, cyc, head[15:0], head[47:16]);
          end
        end
        prev_out = now_out;
      end else if (exp_q.size() != 0 && exp_q[0][47:16] < 32'(cyc)) begin
        head = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_event cyc=%0d got out=%h required out=%h at cyc %0d",
                 cyc, now_out, head[15:0], head[47:16]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, queue depth %0d required 0", exp_q.size());
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    exp_loss   = 8'd0;
    step(3);

    // Reset state
    n_tests++;
    if (cur_out() !== pk(4'b1100, 4'd0, 8'd0) || state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got out=%h state=%0d required out=%h state=0",
               cur_out(), state_dbg, pk(4'b1100, 4'd0, 8'd0));
    end
    prev_out = pk(4'b1100, 4'd0, 8'd0);
    mon_en   = 1'b1;

    // Clean bring-up: pll_rst for 4 cycles, lock 6 cycles into WAIT_LOCK, ready 11 later
    rst = 1'b0;
    expect_at(4, pk(4'b0100, 4'd0, 8'd0));
    step(10);
    pll_locked = 1'b1;
    expect_at(11, pk(4'b0010, 4'd0, 8'd0));
    step(14);

    // Three lock losses in RUN
    for (int i = 0; i < 3; i++) loss_cycle();

    // relock_req coincident with the synchronized lock drop: one increment
    exp_loss   = 8'd4;
    pll_locked = 1'b0;
    expect_at(3, pk(4'b1100, 4'd0, exp_loss));
    step(2);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    step(2);
    pll_locked = 1'b1;
    expect_at(2, pk(4'b0100, 4'd0, exp_loss));
    expect_at(11, pk(4'b0010, 4'd0, exp_loss));
    step(12);

    // relock_req alone in RUN: full reset, no count change
    relock_req = 1'b1;
    expect_at(1, pk(4'b1100, 4'd0, exp_loss));
    expect_at(5, pk(4'b0100, 4'd0, exp_loss));
    expect_at(14, pk(4'b0010, 4'd0, exp_loss));
    step(1);
    relock_req = 1'b0;
    step(16);

    // Timeout to FAULT; relock_req in WAIT_LOCK must not disturb the timeout window
    exp_loss   = 8'd5;
    pll_locked = 1'b0;
    expect_at(3,  pk(4'b1100, 4'd0, exp_loss));
    expect_at(7,  pk(4'b0100, 4'd0, exp_loss));
    expect_at(27, pk(4'b1100, 4'd1, exp_loss));
    expect_at(31, pk(4'b0100, 4'd1, exp_loss));
    expect_at(51, pk(4'b0101, 4'd2, exp_loss));
    step(12);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    step(57);

    // Leave FAULT, time out once, then an unstable lock in STABLE keeps retry_cnt at 1
    relock_req = 1'b1;
    expect_at(1,  pk(4'b1100, 4'd0, exp_loss));
    expect_at(5,  pk(4'b0100, 4'd0, exp_loss));
    expect_at(25, pk(4'b1100, 4'd1, exp_loss));
    expect_at(29, pk(4'b0100, 4'd1, exp_loss));
    expect_at(51, pk(4'b0010, 4'd0, exp_loss));
    step(1);
    relock_req = 1'b0;
    step(30);
    pll_locked = 1'b1;
    step(6);
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(14);

    // Saturating lock-loss counter
    for (int i = 0; i < 260; i++) loss_cycle();

    // rst asserted in the middle of STABLE
    pll_locked = 1'b0;
    expect_at(3, pk(4'b1100, 4'd0, 8'd255));
    step(5);
    pll_locked = 1'b1;
    expect_at(2, pk(4'b0100, 4'd0, 8'd255));
    step(5);
    rst = 1'b1;
    expect_at(1, pk(4'b1100, 4'd0, 8'd0));
    step(3);
    rst = 1'b0;
    expect_at(4,  pk(4'b0100, 4'd0, 8'd0));
    expect_at(13, pk(4'b0010, 4'd0, 8'd0));
    step(20);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending events required 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
